alu_uart_interface: RTL and testbench
=====================================

ALU_UART_INTERFACE -- requirements
Module: alu_uart_interface

Interface
REQ-001 Parameter NBITS, default 8, data width of operands, result and UART bytes.
REQ-002 Parameter COD_OP, default 6, opcode width driven to the ALU.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rx_data  input  NBITS  byte from UART receiver; valid only while rx_done=1.
REQ-006 rx_done  input  1  one-cycle pulse, rx_data valid.
REQ-007 alu_result  input  NBITS  combinational result from the downstream ALU.
REQ-008 tx_busy  input  1  UART transmitter busy; tx_start not accepted while high.
REQ-009 operando_A  output  NBITS  registered operand A to the ALU.
REQ-010 operando_B  output  NBITS  registered operand B to the ALU.
REQ-011 cod_operacion  output  COD_OP  registered opcode to the ALU.
REQ-012 tx_data  output  NBITS  registered result byte to UART transmitter.
REQ-013 tx_start  output  1  registered one-cycle pulse requesting transmission of tx_data.

Function
REQ-014 FSM states: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND; one-hot or binary encoding at implementer's choice.
REQ-015 Frame order fixed: byte 1 = A, byte 2 = B, byte 3 = opcode.
REQ-016 WAIT_A & rx_done: operando_A <= rx_data; next state WAIT_B.
REQ-017 WAIT_B & rx_done: operando_B <= rx_data; next state WAIT_OP.
REQ-018 WAIT_OP & rx_done: cod_operacion <= rx_data[COD_OP-1:0], upper bits discarded; next state EXEC.
REQ-019 In WAIT_A/WAIT_B/WAIT_OP without rx_done: state and all registers hold.
REQ-020 EXEC: exactly one cycle; tx_data <= alu_result (ALU settled from registered inputs); next state SEND.
REQ-021 SEND & tx_busy=0: tx_start <= 1 for exactly one cycle; next state WAIT_A.
REQ-022 SEND & tx_busy=1: stay in SEND, tx_start=0, tx_data held.
REQ-023 tx_start SHALL be 0 in every cycle except the single cycle following the SEND exit edge.
REQ-024 rx_done asserted in EXEC or SEND SHALL be ignored (byte dropped, no register change).
REQ-025 Latency: opcode rx_done sampled at edge N, tx_data valid after edge N+1, tx_start high between edges N+2 and N+3 when tx_busy=0 at edge N+2.
REQ-026 operando_A, operando_B, cod_operacion SHALL hold their values after a frame until overwritten by the next frame.
REQ-027 No arithmetic in this block; widths pass through unchanged except opcode truncation of REQ-018.
REQ-028 Back-to-back frames: first byte of the next frame SHALL be accepted in the cycle immediately after SEND exit.

Reset
REQ-029 rst_n=0 SHALL immediately force state WAIT_A and operando_A, operando_B, cod_operacion, tx_data, tx_start to 0, independent of clk.
REQ-030 Reset mid-frame SHALL discard partially received bytes; first rx_done after release is treated as A.
REQ-031 Reset release SHALL be synchronous-safe: first state update on the first rising clk edge with rst_n=1.

Verification
REQ-032 ADD: bytes 0x05,0x03,0x20, tx_busy=0 -> tx_data=0x08, one tx_start pulse 2 cycles after opcode rx_done edge.
REQ-033 SUB wrap and opcode truncation: bytes 0x03,0x05,0xE2 -> cod_operacion=0x22, tx_data=0xFE.
REQ-034 Invalid opcode: bytes 0x12,0x34,0x3F -> tx_data=0xFF, one tx_start pulse.
REQ-035 Backpressure: tx_busy=1 for 10 cycles during SEND plus rx_done pulse with 0xAA -> no tx_start until cycle after tx_busy falls, tx_data unchanged, 0xAA not captured.
REQ-036 Reset mid-frame: A=0x11, B=0x22 received, rst_n pulsed low -> all outputs 0; then 0x0F,0xF0,0x25 -> tx_data=0xFF (OR).
REQ-037 Back-to-back: two frames (0x01,0x01,0x20) then (0xF0,0x0F,0x24) with rx_done one cycle after first tx_start -> tx_data 0x02 then 0x00, two tx_start pulses.

Source files
------------

// File: rtl/alu_uart_interface.sv
// -----------------------------------------------------------------------------
// alu_uart_interface
//
// Glue between a byte-oriented UART and a combinational ALU. The UART delivers
// a fixed three-byte frame: operand A, operand B, opcode. Once the opcode has
// been captured, the ALU sees stable registered inputs. One cycle later the
// ALU result is latched into tx_data. After that, a single-cycle tx_start
// pulse is issued as soon as the transmitter is not busy.
//
// Parameters
//   NBITS   data width of operands, result and UART bytes
//   COD_OP  opcode width driven to the ALU (must not exceed NBITS)
//
// Ports
//   clk            system clock, all state changes on the rising edge
//   rst_n          asynchronous active-low reset
//   rx_data        received byte, meaningful only while rx_done is high
//   rx_done        one-cycle strobe from the UART receiver
//   alu_result     combinational result from the downstream ALU
//   tx_busy        UART transmitter busy, holds off tx_start
//   operando_A     registered operand A to the ALU
//   operando_B     registered operand B to the ALU
//   cod_operacion  registered opcode to the ALU (low COD_OP bits of the byte)
//   tx_data        registered result byte for the UART transmitter
//   tx_start       registered one-cycle transmit request
// -----------------------------------------------------------------------------
module alu_uart_interface #(
    parameter int NBITS  = 8,
    parameter int COD_OP = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NBITS-1:0]  rx_data,
    input  logic              rx_done,
    input  logic [NBITS-1:0]  alu_result,
    input  logic              tx_busy,
    output logic [NBITS-1:0]  operando_A,
    output logic [NBITS-1:0]  operando_B,
    output logic [COD_OP-1:0] cod_operacion,
    output logic [NBITS-1:0]  tx_data,
    output logic              tx_start
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4
    } state_t;

    state_t             state_reg, state_next;
    logic [NBITS-1:0]   opa_reg,   opa_next;
    logic [NBITS-1:0]   opb_reg,   opb_next;
    logic [COD_OP-1:0]  cod_reg,   cod_next;
    logic [NBITS-1:0]   txd_reg,   txd_next;
    logic               txs_reg,   txs_next;

    // State and datapath registers. Reset acts immediately, independent of
    // clk, so a frame in progress is abandoned and the next byte is taken as A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= WAIT_A;
            opa_reg   <= '0;
            opb_reg   <= '0;
            cod_reg   <= '0;
            txd_reg   <= '0;
            txs_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            opa_reg   <= opa_next;
            opb_reg   <= opb_next;
            cod_reg   <= cod_next;
            txd_reg   <= txd_next;
            txs_reg   <= txs_next;
        end
    end

    // Next-state and datapath update. Everything holds by default. tx_start
    // defaults low, so it can only be high for the single cycle after the
    // edge that leaves SEND.
    always_comb begin
        state_next = state_reg;
        opa_next   = opa_reg;
        opb_next   = opb_reg;
        cod_next   = cod_reg;
        txd_next   = txd_reg;
        txs_next   = 1'b0;

        case (state_reg)
            WAIT_A: begin
                if (rx_done) begin
                    opa_next   = rx_data;
                    state_next = WAIT_B;
                end
            end
            WAIT_B: begin
                if (rx_done) begin
                    opb_next   = rx_data;
                    state_next = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (rx_done) begin
                    // Only the low bits form the opcode; the rest of the
                    // byte is dropped.
                    cod_next   = rx_data[COD_OP-1:0];
                    state_next = EXEC;
                end
            end
            EXEC: begin
                // Operands and opcode became stable at the previous edge, so
                // the ALU output has had a full cycle to settle.
                txd_next   = alu_result;
                state_next = SEND;
            end
            SEND: begin
                // Bytes arriving in EXEC/SEND are dropped, so rx_done is
                // not looked at here.
                if (!tx_busy) begin
                    txs_next   = 1'b1;
                    state_next = WAIT_A;
                end
            end
            default: begin
                state_next = WAIT_A;
            end
        endcase
    end

    assign operando_A    = opa_reg;
    assign operando_B    = opb_reg;
    assign cod_operacion = cod_reg;
    assign tx_data       = txd_reg;
    assign tx_start      = txs_reg;

endmodule

// File: tb/tb_alu_uart_interface.sv
// -----------------------------------------------------------------------------
// tb_alu_uart_interface
//
// Self-checking bench for alu_uart_interface. A behavioural ALU stand-in
// drives alu_result from the DUT's registered operands. Directed frames come
// from a vector table. Randomized frames are checked against the same
// opcode rules, applied to the bytes that were sent. Hand-written sequences
// cover asynchronous reset in the middle of a frame.
// -----------------------------------------------------------------------------
module tb_alu_uart_interface;

    localparam int NBITS  = 8;
    localparam int COD_OP = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NBITS-1:0]  rx_data;
    logic              rx_done;
    logic [NBITS-1:0]  alu_result;
    logic              tx_busy;
    logic [NBITS-1:0]  operando_A;
    logic [NBITS-1:0]  operando_B;
    logic [COD_OP-1:0] cod_operacion;
    logic [NBITS-1:0]  tx_data;
    logic              tx_start;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_uart_interface #(.NBITS(NBITS), .COD_OP(COD_OP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_done       (rx_done),
        .alu_result    (alu_result),
        .tx_busy       (tx_busy),
        .operando_A    (operando_A),
        .operando_B    (operando_B),
        .cod_operacion (cod_operacion),
        .tx_data       (tx_data),
        .tx_start      (tx_start)
    );

    // Opcode semantics of the downstream ALU. Unknown opcodes yield all ones.
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> 1;
            6'h03:   return 8'($signed(a) >>> 1);
            default: return 8'hFF;
        endcase
    endfunction

    always_comb alu_result = alu_ref(operando_A, operando_B, cod_operacion);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Optional idle gap with garbage on rx_data, then one rx_done strobe.
    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            rx_data = 8'($urandom);
            rx_done = 1'b0;
            @(posedge clk); #1;
        end
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    // Sends one frame, then follows the result phase edge by edge. Let N be
    // the edge that samples the opcode. tx_busy is high at edges N+1..N+busy.
    // The transmit pulse therefore follows edge N+max(2, busy+1). When inject
    // is set, 0xAA is strobed into the EXEC edge and again at edge N+4; both
    // must be dropped. The task returns right after the pulse edge, so the
    // next call's first byte is offered back-to-back.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input int busy, input bit inject, input int gap,
                             input logic [5:0] exp_cod, input logic [7:0] exp_res,
                             input string tag);
        int expk;
        int pulses;
        send_byte(a, gap);
        check($sformatf("%s tx_start_low_after_A", tag), 32'(tx_start), 32'd0);
        check($sformatf("%s operando_A", tag), 32'(operando_A), 32'(a));
        send_byte(b, gap);
        check($sformatf("%s operando_B", tag), 32'(operando_B), 32'(b));
        check($sformatf("%s operando_A_hold", tag), 32'(operando_A), 32'(a));
        send_byte(op, gap);
        check($sformatf("%s cod_operacion", tag), 32'(cod_operacion), 32'(exp_cod));
        check($sformatf("%s tx_start_low_exec", tag), 32'(tx_start), 32'd0);
        tx_busy = (busy >= 1);
        if (inject) begin
            rx_data = 8'hAA;
            rx_done = 1'b1;
        end
        expk   = (busy + 1 > 2) ? busy + 1 : 2;
        pulses = 0;
        for (int k = 1; k <= expk; k++) begin
            @(posedge clk); #1;
            check($sformatf("%s tx_data@%0d", tag, k), 32'(tx_data), 32'(exp_res));
            check($sformatf("%s tx_start@%0d", tag, k), 32'(tx_start), 32'(k == expk));
            if (tx_start) pulses++;
            tx_busy = (k + 1 <= busy);
            rx_done = inject && (k == 3);
            rx_data = (inject && (k == 3)) ? 8'hAA : 8'($urandom);
        end
        rx_done = 1'b0;
        tx_busy = 1'b0;
        check($sformatf("%s operando_A_after", tag), 32'(operando_A), 32'(a));
        check($sformatf("%s operando_B_after", tag), 32'(operando_B), 32'(b));
        check($sformatf("%s cod_after", tag), 32'(cod_operacion), 32'(exp_cod));
        $display("frame %s: A=%02h B=%02h op=%02h busy=%0d inject=%0d -> tx_data=%02h pulses=%0d (expected %02h)",
                 tag, a, b, op, busy, inject, tx_data, pulses, exp_res);
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s operando_A", tag), 32'(operando_A), 32'd0);
        check($sformatf("%s operando_B", tag), 32'(operando_B), 32'd0);
        check($sformatf("%s cod_operacion", tag), 32'(cod_operacion), 32'd0);
        check($sformatf("%s tx_data", tag), 32'(tx_data), 32'd0);
        check($sformatf("%s tx_start", tag), 32'(tx_start), 32'd0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        int         busy;
        bit         inject;
        logic [5:0] exp_cod;
        logic [7:0] exp_res;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [7:0] ops [8];
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] rop;
        int         rbusy;

        // Directed frames. Entries 4 and 5 run back-to-back.
        vecs[0] = '{8'h05, 8'h03, 8'h20, 0,  1'b0, 6'h20, 8'h08};  // ADD
        vecs[1] = '{8'h03, 8'h05, 8'hE2, 0,  1'b0, 6'h22, 8'hFE};  // SUB wrap, truncation
        vecs[2] = '{8'h12, 8'h34, 8'h3F, 0,  1'b0, 6'h3F, 8'hFF};  // invalid opcode
        vecs[3] = '{8'h07, 8'h09, 8'h24, 10, 1'b1, 6'h24, 8'h01};  // backpressure + 0xAA
        vecs[4] = '{8'h01, 8'h01, 8'h20, 0,  1'b0, 6'h20, 8'h02};  // back-to-back #1
        vecs[5] = '{8'hF0, 8'h0F, 8'h24, 0,  1'b0, 6'h24, 8'h00};  // back-to-back #2
        ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03};

        rst_n   = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        tx_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("post_reset_idle");

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].busy, vecs[i].inject, 0,
                      vecs[i].exp_cod, vecs[i].exp_res, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a frame, asserted between clock edges.
        @(posedge clk); #1;
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        check("midframe operando_B", 32'(operando_B), 32'h22);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk); #1;
        check_all_zero("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(8'h0F, 8'hF0, 8'h25, 0, 1'b0, 0, 6'h25, 8'hFF, "after_reset");

        // Randomized frames with idle gaps and transmitter backpressure.
        for (int i = 0; i < 24; i++) begin
            ra    = 8'($urandom);
            rb    = 8'($urandom);
            rop   = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                  : (ops[$urandom_range(0, 7)] | {2'($urandom), 6'h00});
            rbusy = $urandom_range(0, 5);
            run_frame(ra, rb, rop, rbusy, (rbusy >= 4) && ($urandom_range(0, 1) == 1),
                      $urandom_range(0, 2), rop[5:0], alu_ref(ra, rb, rop[5:0]),
                      $sformatf("rand%0d", i));
        end

        // Quiet tail: no further transmit requests without a new frame.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("idle tx_start@%0d", i), 32'(tx_start), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
